uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
Host-side responder for the UART block. It consumes received bytes from the UART RX FIFO, parses read/write command frames, and executes them as transactions on a simple req/ack register bus. It returns one reply byte per frame through the UART TX FIFO, making it the far end of the serial link that lets a remote host access on-chip registers.

Parameters:
Data_bits, 9, UART frame width including parity bit; payload width W = Data_bits-1 (8 by default)
Byte_timeout, 100000, clk cycles allowed between bytes of one frame before the frame is abandoned
Bus_timeout, 255, clk cycles allowed for bus_ack after bus_req rises
Cnt_width, 8, width of the saturating parity-error counter

Ports:
clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
rx_empty  in  1  UART RX FIFO empty; r_data is valid whenever this is 0 (first-word fall-through)
r_data  in  W  RX FIFO head byte
rd_uart  out  1  one-cycle pop of the RX FIFO
incorrect_send  in  1  parity-error pulse from the UART receiver
tx_full  in  1  UART TX FIFO full
wr_uart  out  1  one-cycle push into the TX FIFO
w_data  out  W  reply byte, valid while wr_uart=1
bus_req  out  1  bus transaction request, held until ack or timeout
bus_we  out  1  1 = write, 0 = read; stable while bus_req=1
bus_addr  out  W  register address
bus_wdata  out  W  write data
bus_ack  in  1  transaction complete; sampled only while bus_req=1
bus_rdata  in  W  read data, valid in the bus_ack cycle
busy  out  1  high in every state except IDLE
frame_err  out  1  one-cycle pulse when a byte timeout abandons a frame
parity_err_cnt  out  Cnt_width  saturating count of incorrect_send pulses

Behaviour:
- Reset: one clock, synchronous, active-high. Every output resets to 0. FSM goes to IDLE and both timers clear. A Reset asserted mid-frame or mid-bus-transaction takes effect at the next edge and drops bus_req; no reply is sent.
- Frame formats:
  - Write: 0x57 ('W'), addr, data. Reply 0x4B ('K') on ack, or 0x45 ('E') on bus timeout.
  - Read: 0x52 ('R'), addr. Reply the bus_rdata byte on ack, or 0x45 on bus timeout.
  - Any other first byte: reply 0x3F ('?') with no bus activity.
- Byte consumption: in IDLE, GET_ADDR and GET_DATA, when rx_empty=0, assert rd_uart for exactly one cycle and capture r_data in that same cycle. At most one pop per cycle.
- States and transitions:
  - IDLE: on a pop, cmd=0x57 or 0x52 goes to GET_ADDR; any other value loads reply 0x3F and goes to SEND_RESP.
  - GET_ADDR: pop goes to GET_DATA for a write, or BUS_REQ for a read.
  - GET_DATA: pop goes to BUS_REQ.
  - BUS_REQ: bus_req=1 with bus_addr, bus_we and bus_wdata stable. When bus_ack=1, latch bus_rdata (read) or 0x4B (write) as the reply, drop bus_req on the next edge, and go to SEND_RESP. If the bus timer reaches Bus_timeout, drop bus_req, load reply 0x45, and go to SEND_RESP. If ack and timeout occur in the same cycle, ack wins.
  - SEND_RESP: while tx_full=1, wait with wr_uart=0. Otherwise pulse wr_uart for one cycle with w_data=reply, then go to IDLE.
- Latency: write reply pushed 2 cycles after the ack cycle; bus_req rises 1 cycle after the last frame byte is popped.
- Byte timer: runs in GET_ADDR and GET_DATA and reloads on each pop. When it reaches Byte_timeout: pulse frame_err, go to IDLE, send no reply. The timer does not run in IDLE.
- Bus timer: starts when BUS_REQ is entered.
- Parity counter: each incorrect_send pulse increments parity_err_cnt in any state, saturating at 2^Cnt_width-1. It does not affect frame parsing.
- Data held in the RX FIFO while in BUS_REQ or SEND_RESP stays unpopped until the FSM returns to IDLE.

Decomposition:
- Package uart_cmd_pkg holds:
  - state enum (IDLE, GET_ADDR, GET_DATA, BUS_REQ, SEND_RESP)
  - command constants CMD_WR=0x57, CMD_RD=0x52
  - response constants RSP_OK=0x4B, RSP_ERR=0x45, RSP_BAD=0x3F
- One natural sub-module: uart_timeout_cnt, a parameterised clear/enable counter with a terminal-count flag. It is instantiated twice, once as the byte timer and once as the bus timer.

Test Plan:
- Write frame: push 0x57, 0x10, 0xA5; ack 2 cycles after bus_req -> bus_we=1, bus_addr=0x10, bus_wdata=0xA5; exactly one wr_uart with w_data=0x4B; busy returns to 0.
- Read frame: push 0x52, 0x22; ack with bus_rdata=0x3C -> bus_we=0, bus_addr=0x22; one wr_uart with w_data=0x3C.
- Unknown command: push 0x41 -> no bus_req; one wr_uart with w_data=0x3F.
- Byte timeout: push 0x57, 0x10, then nothing for Byte_timeout cycles -> one frame_err pulse, no wr_uart; a following 0x52, 0x05 frame completes normally.
- Bus timeout and backpressure:
  - Read frame with bus_ack never asserted -> bus_req drops after Bus_timeout cycles.
  - Hold tx_full=1 for 20 cycles -> wr_uart stays 0 throughout, then a single push of w_data=0x45.
- Parity and reset:
  - 3 incorrect_send pulses -> parity_err_cnt=3; 300 pulses -> saturates at 255.
  - Reset asserted while bus_req=1 -> all outputs 0 on the next edge, and no reply is sent.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command responder: FSM encodings and
// command/response byte values.
package uart_cmd_pkg;

    // FSM state encodings
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GET_ADDR  = 3'd1;
    localparam logic [2:0] S_GET_DATA  = 3'd2;
    localparam logic [2:0] S_BUS_REQ   = 3'd3;
    localparam logic [2:0] S_SEND_RESP = 3'd4;

    // Command bytes
    localparam logic [7:0] CMD_WR = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD = 8'h52;  // 'R'

    // Reply bytes
    localparam logic [7:0] RSP_OK  = 8'h4B; // 'K'
    localparam logic [7:0] RSP_ERR = 8'h45; // 'E'
    localparam logic [7:0] RSP_BAD = 8'h3F; // '?'

endpackage

// File: rtl/uart_timeout_cnt.sv
// Clear/enable up-counter with a terminal-count flag. The flag rises in the
// LIMIT-th enabled cycle after a clear, and the count then holds there.
module uart_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic Reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    // Count enabled cycles; clear has priority, stop once terminal is reached
    always_ff @(posedge clk) begin
        if (Reset || i_clr)
            r_cnt <= '0;
        else if (i_en && !o_tc)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tc = (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses 'W'/'R' command frames popped from the UART RX FIFO, runs them as
// req/ack register bus transactions and pushes one reply byte per frame.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int Data_bits    = 9,
    parameter int Byte_timeout = 100000,
    parameter int Bus_timeout  = 255,
    parameter int Cnt_width    = 8
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 rx_empty,
    input  logic [Data_bits-2:0] r_data,
    output logic                 rd_uart,
    input  logic                 incorrect_send,
    input  logic                 tx_full,
    output logic                 wr_uart,
    output logic [Data_bits-2:0] w_data,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [Data_bits-2:0] bus_addr,
    output logic [Data_bits-2:0] bus_wdata,
    input  logic                 bus_ack,
    input  logic [Data_bits-2:0] bus_rdata,
    output logic                 busy,
    output logic                 frame_err,
    output logic [Cnt_width-1:0] parity_err_cnt
);
    localparam int W = Data_bits - 1;

    logic [2:0]           r_state;
    logic                 r_we;
    logic [W-1:0]         r_addr;
    logic [W-1:0]         r_wdata;
    logic [W-1:0]         r_reply;
    logic                 r_wr_uart;
    logic [W-1:0]         r_w_data;
    logic                 r_frame_err;
    logic [Cnt_width-1:0] r_par_cnt;

    logic w_rx_state;
    logic w_pop;
    logic w_byte_tc;
    logic w_bus_tc;

    // Only the frame-collecting states pull bytes; later bytes wait in the FIFO
    assign w_rx_state = (r_state == S_IDLE) || (r_state == S_GET_ADDR) ||
                        (r_state == S_GET_DATA);
    assign w_pop      = w_rx_state && !rx_empty && !Reset;

    // Inter-byte timer: runs only mid-frame and restarts on every pop
    uart_timeout_cnt #(.LIMIT(Byte_timeout)) u_byte_tmr (
        .clk   (clk),
        .Reset (Reset),
        .i_clr (!(r_state == S_GET_ADDR || r_state == S_GET_DATA) || w_pop),
        .i_en  (r_state == S_GET_ADDR || r_state == S_GET_DATA),
        .o_tc  (w_byte_tc)
    );

    // Bus timer: counts from entry into BUS_REQ
    uart_timeout_cnt #(.LIMIT(Bus_timeout)) u_bus_tmr (
        .clk   (clk),
        .Reset (Reset),
        .i_clr (r_state != S_BUS_REQ),
        .i_en  (r_state == S_BUS_REQ),
        .o_tc  (w_bus_tc)
    );

    // Frame parser and transaction sequencer
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_reply     <= '0;
            r_wr_uart   <= 1'b0;
            r_w_data    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_uart   <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (r_data == W'(CMD_WR) || r_data == W'(CMD_RD)) begin
                            r_we    <= (r_data == W'(CMD_WR));
                            r_state <= S_GET_ADDR;
                        end else begin
                            r_reply <= W'(RSP_BAD);
                            r_state <= S_SEND_RESP;
                        end
                    end
                end
                S_GET_ADDR: begin
                    if (w_pop) begin
                        r_addr  <= r_data;
                        r_state <= r_we ? S_GET_DATA : S_BUS_REQ;
                    end else if (w_byte_tc) begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_GET_DATA: begin
                    if (w_pop) begin
                        r_wdata <= r_data;
                        r_state <= S_BUS_REQ;
                    end else if (w_byte_tc) begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_BUS_REQ: begin
                    // Ack beats a coincident timeout
                    if (bus_ack) begin
                        r_reply <= r_we ? W'(RSP_OK) : bus_rdata;
                        r_state <= S_SEND_RESP;
                    end else if (w_bus_tc) begin
                        r_reply <= W'(RSP_ERR);
                        r_state <= S_SEND_RESP;
                    end
                end
                S_SEND_RESP: begin
                    if (!tx_full) begin
                        r_wr_uart <= 1'b1;
                        r_w_data  <= r_reply;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Saturating parity-error counter, independent of frame state
    always_ff @(posedge clk) begin
        if (Reset)
            r_par_cnt <= '0;
        else if (incorrect_send && r_par_cnt != {Cnt_width{1'b1}})
            r_par_cnt <= r_par_cnt + 1'b1;
    end

    assign rd_uart        = w_pop;
    assign wr_uart        = r_wr_uart;
    assign w_data         = r_w_data;
    assign bus_req        = (r_state == S_BUS_REQ);
    assign bus_we         = r_we;
    assign bus_addr       = r_addr;
    assign bus_wdata      = r_wdata;
    assign busy           = (r_state != S_IDLE);
    assign frame_err      = r_frame_err;
    assign parity_err_cnt = r_par_cnt;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: RX FIFO model, TX/bus/frame_err
// monitors and hand-computed expected replies.
module tb_uart_cmd_responder;
    localparam int BYTE_TO = 200;
    localparam int BUS_TO  = 40;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       incorrect_send = 1'b0;
    logic       tx_full = 1'b0;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       bus_req, bus_we;
    logic [7:0] bus_addr, bus_wdata;
    logic       bus_ack = 1'b0;
    logic [7:0] bus_rdata = 8'h00;
    logic       busy, frame_err;
    logic [7:0] parity_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    uart_cmd_responder #(
        .Data_bits(9), .Byte_timeout(BYTE_TO), .Bus_timeout(BUS_TO), .Cnt_width(8)
    ) dut (
        .clk(clk), .Reset(Reset), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .incorrect_send(incorrect_send), .tx_full(tx_full),
        .wr_uart(wr_uart), .w_data(w_data), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .busy(busy), .frame_err(frame_err),
        .parity_err_cnt(parity_err_cnt)
    );

    always #5 clk = ~clk;

    // RX FIFO model: written by the stimulus, popped on rd_uart
    logic [7:0] rx_mem [0:255];
    logic [7:0] wp = 8'd0;
    logic [7:0] rp = 8'd0;
    assign rx_empty = (rp == wp);
    assign r_data   = rx_mem[rp];

    always @(posedge clk) if (rd_uart) rp <= rp + 8'd1;

    // Monitors
    int         tx_cnt  = 0;
    logic [7:0] tx_last = 8'h00;
    int         req_cyc = 0;
    int         fe_cnt  = 0;
    always @(posedge clk) begin
        if (wr_uart) begin
            tx_cnt  <= tx_cnt + 1;
            tx_last <= w_data;
        end
        if (bus_req)   req_cyc <= req_cyc + 1;
        if (frame_err) fe_cnt  <= fe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[wp] = b;
        wp = wp + 8'd1;
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (!bus_req && n < max) begin
            tick(1);
            n++;
        end
        chk("req_seen", {31'd0, bus_req}, 32'd1);
    endtask

    int tx0, rq0, fe0;

    initial begin
        // Reset state
        tick(2);
        chk("rst_busy",   {31'd0, busy},    32'd0);
        chk("rst_req",    {31'd0, bus_req}, 32'd0);
        chk("rst_wr",     {31'd0, wr_uart}, 32'd0);
        chk("rst_rd",     {31'd0, rd_uart}, 32'd0);
        chk("rst_fe",     {31'd0, frame_err}, 32'd0);
        chk("rst_par",    {24'd0, parity_err_cnt}, 32'd0);
        Reset = 1'b0;
        tick(2);

        // Write frame, ack two cycles into bus_req
        tx0 = tx_cnt;
        push(8'h57); push(8'h10); push(8'hA5);
        wait_req(20);
        chk("wr_we",    {31'd0, bus_we}, 32'd1);
        chk("wr_addr",  {24'd0, bus_addr},  32'h10);
        chk("wr_wdata", {24'd0, bus_wdata}, 32'hA5);
        tick(1);
        bus_ack = 1'b1;
        tick(1);
        bus_ack = 1'b0;
        chk("wr_req_drop", {31'd0, bus_req}, 32'd0);
        chk("wr_no_early", {31'd0, wr_uart}, 32'd0);
        tick(1);
        chk("wr_push",  {31'd0, wr_uart}, 32'd1);
        chk("wr_wdat",  {24'd0, w_data},  32'h4B);
        tick(3);
        chk("wr_txcnt", tx_cnt - tx0, 32'd1);
        chk("wr_busy",  {31'd0, busy}, 32'd0);
        chk("wr_fifo",  {24'd0, wp - rp}, 32'd0);

        // Read frame
        tx0 = tx_cnt;
        push(8'h52); push(8'h22);
        wait_req(20);
        chk("rd_we",   {31'd0, bus_we}, 32'd0);
        chk("rd_addr", {24'd0, bus_addr}, 32'h22);
        bus_rdata = 8'h3C; bus_ack = 1'b1;
        tick(1);
        bus_ack = 1'b0;
        tick(4);
        chk("rd_txcnt", tx_cnt - tx0, 32'd1);
        chk("rd_reply", {24'd0, tx_last}, 32'h3C);

        // Unknown command
        tx0 = tx_cnt; rq0 = req_cyc;
        push(8'h41);
        tick(6);
        chk("bad_noreq", req_cyc - rq0, 32'd0);
        chk("bad_txcnt", tx_cnt - tx0, 32'd1);
        chk("bad_reply", {24'd0, tx_last}, 32'h3F);

        // Byte timeout mid-frame, then a clean read
        tx0 = tx_cnt; fe0 = fe_cnt;
        push(8'h57); push(8'h10);
        tick(BYTE_TO + 10);
        chk("bto_fe",    fe_cnt - fe0, 32'd1);
        chk("bto_notx",  tx_cnt - tx0, 32'd0);
        chk("bto_busy",  {31'd0, busy}, 32'd0);
        push(8'h52); push(8'h05);
        wait_req(20);
        chk("bto_addr",  {24'd0, bus_addr}, 32'h05);
        bus_rdata = 8'h99; bus_ack = 1'b1;
        tick(1);
        bus_ack = 1'b0;
        tick(4);
        chk("bto_txcnt", tx_cnt - tx0, 32'd1);
        chk("bto_reply", {24'd0, tx_last}, 32'h99);

        // Bus timeout with TX backpressure
        tx_full = 1'b1;
        tx0 = tx_cnt; rq0 = req_cyc;
        push(8'h52); push(8'h33);
        wait_req(20);
        tick(BUS_TO + 5);
        chk("bus_to_cyc", req_cyc - rq0, BUS_TO);
        chk("bus_to_req", {31'd0, bus_req}, 32'd0);
        chk("bp_busy",    {31'd0, busy}, 32'd1);
        tick(20);
        chk("bp_notx",    tx_cnt - tx0, 32'd0);
        tx_full = 1'b0;
        tick(3);
        chk("bp_txcnt",   tx_cnt - tx0, 32'd1);
        chk("bp_reply",   {24'd0, tx_last}, 32'h45);

        // Parity counter: 3 pulses, then saturation
        for (int i = 0; i < 3; i++) begin
            incorrect_send = 1'b1; tick(1);
            incorrect_send = 1'b0; tick(1);
        end
        chk("par_3", {24'd0, parity_err_cnt}, 32'd3);
        for (int i = 0; i < 297; i++) begin
            incorrect_send = 1'b1; tick(1);
            incorrect_send = 1'b0; tick(1);
        end
        chk("par_sat", {24'd0, parity_err_cnt}, 32'd255);

        // Reset during a bus transaction
        tx0 = tx_cnt;
        push(8'h57); push(8'h01); push(8'h02);
        wait_req(20);
        Reset = 1'b1;
        tick(1);
        chk("mr_req",  {31'd0, bus_req}, 32'd0);
        chk("mr_busy", {31'd0, busy},    32'd0);
        chk("mr_wr",   {31'd0, wr_uart}, 32'd0);
        chk("mr_par",  {24'd0, parity_err_cnt}, 32'd0);
        chk("mr_addr", {24'd0, bus_addr}, 32'd0);
        Reset = 1'b0;
        tick(10);
        chk("mr_notx", tx_cnt - tx0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
